startup_sequencer: RTL and testbench



---
 rtl/startup_sequencer.sv | 170 +++++++++++++++++
 tb/tb_startup_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/startup_sequencer.sv
// Power-up reset sequencer on the raw board clock: qualifies PLL lock, then releases the
// downstream reset domains one at a time, optionally waiting for each domain's ready ack.
module startup_sequencer #(
   parameter int unsigned       STAGES      = 3,
   parameter int unsigned       LOCK_FILTER = 16,
   parameter int unsigned       STAGE_DELAY = 256,
   parameter int unsigned       TIMEOUT     = 65536,
   parameter logic [STAGES-1:0] ACK_MASK    = {STAGES{1'b0}},
   parameter int unsigned       FLASH_BITS  = 24
) (
   input  logic              clk_26,
   input  logic              rst_n,
   input  logic              lock_i,
   input  logic [STAGES-1:0] ack_i,
   input  logic              restart_i,
   output logic [STAGES-1:0] enable_o,
   output logic [2:0]        state_o,
   output logic [2:0]        stage_o,
   output logic              fault_o,
   output logic              led_o
);

   localparam int unsigned FILT_W = $clog2(LOCK_FILTER) + 1;
   localparam int unsigned DLY_W  = $clog2(STAGE_DELAY) + 1;
   localparam int unsigned TO_W   = $clog2(TIMEOUT) + 1;

   localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
   localparam logic [DLY_W-1:0]  DLY_LAST   = DLY_W'(STAGE_DELAY - 1);
   localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);
   localparam logic [2:0]        STAGE_LAST = 3'(STAGES - 1);

   typedef enum logic [2:0] {
      StReset    = 3'd0,
      StWaitLock = 3'd1,
      StDelay    = 3'd2,
      StWaitAck  = 3'd3,
      StRun      = 3'd4,
      StFault    = 3'd5
   } state_t;

   state_t            state;
   logic              lock_meta;
   logic              lock_s;
   logic [STAGES-1:0] ack_meta;
   logic [STAGES-1:0] ack_s;
   logic [FILT_W-1:0] filt;
   logic [DLY_W-1:0]  dly;
   logic [TO_W-1:0]   tmo;
   logic [2:0]        stage;
   logic [STAGES-1:0] enable;
   logic [STAGES-1:0] stage_bit;
   logic              fault;
   logic              led;
   logic [FLASH_BITS-1:0] flash;
   logic              lock_lost;
   logic              stage_done;

   assign stage_bit  = STAGES'(1) << stage;
   assign lock_lost  = !lock_s && (state == StDelay || state == StWaitAck || state == StRun);
   // A stage without an ack requirement is done as soon as it is enabled.
   assign stage_done = ((ACK_MASK & stage_bit) == '0) || ((ack_s & stage_bit) != '0);

   always_ff @(posedge clk_26) begin
      if (!rst_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
         ack_meta  <= '0;
         ack_s     <= '0;
      end else begin
         lock_meta <= lock_i;
         lock_s    <= lock_meta;
         ack_meta  <= ack_i;
         ack_s     <= ack_meta;
      end
   end

   always_ff @(posedge clk_26) begin
      if (!rst_n) begin
         flash <= '0;
      end else begin
         flash <= flash + 1'b1;
      end
   end

   always_ff @(posedge clk_26) begin
      if (!rst_n) begin
         state  <= StReset;
         stage  <= '0;
         filt   <= '0;
         dly    <= '0;
         tmo    <= '0;
         enable <= '0;
         fault  <= 1'b0;
         led    <= 1'b0;
      end else begin
         case (state)
            StDelay, StWaitAck: led <= flash[FLASH_BITS-1];
            StRun:              led <= 1'b1;
            StFault:            led <= flash[FLASH_BITS-3];
            default:            led <= 1'b0;
         endcase

         if (lock_lost || (restart_i && state != StReset)) begin
            state  <= StWaitLock;
            stage  <= '0;
            filt   <= '0;
            enable <= '0;
            fault  <= 1'b0;
         end else begin
            case (state)
               StReset: begin
                  state <= StWaitLock;
               end
               StWaitLock: begin
                  if (!lock_s) begin
                     filt <= '0;
                  end else if (filt == FILT_LAST) begin
                     state <= StDelay;
                     stage <= '0;
                     dly   <= '0;
                     filt  <= '0;
                  end else if (filt != '1) begin
                     filt <= filt + 1'b1;
                  end
               end
               StDelay: begin
                  if (dly == DLY_LAST) begin
                     enable <= enable | stage_bit;
                     tmo    <= '0;
                     state  <= StWaitAck;
                  end else if (dly != '1) begin
                     dly <= dly + 1'b1;
                  end
               end
               StWaitAck: begin
                  // An ack arriving on the time-out cycle still counts.
                  if (stage_done) begin
                     if (stage == STAGE_LAST) begin
                        state <= StRun;
                     end else begin
                        stage <= stage + 3'd1;
                        dly   <= '0;
                        state <= StDelay;
                     end
                  end else if (TIMEOUT != 0 && tmo == TO_LAST) begin
                     state  <= StFault;
                     fault  <= 1'b1;
                     enable <= '0;
                  end else if (tmo != '1) begin
                     tmo <= tmo + 1'b1;
                  end
               end
               StRun, StFault: begin
                  state <= state;
               end
               default: begin
                  state <= StReset;
               end
            endcase
         end
      end
   end

   assign enable_o = enable;
   assign state_o  = state;
   assign stage_o  = stage;
   assign fault_o  = fault;
   assign led_o    = led;

endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: directed scenarios with literal timing pins plus a random
// phase, all outputs compared every cycle against a deadline-based behavioural model.
module tb_startup_sequencer;

   localparam int         STAGES = 3;
   localparam int         LF     = 4;
   localparam int         SD     = 8;
   localparam int         TO     = 64;
   localparam int         FB     = 6;
   localparam logic [2:0] MASK   = 3'b010;

   localparam int SEL_EN    = 0;
   localparam int SEL_FAULT = 1;
   localparam int SEL_LED   = 2;
   localparam int SEL_STATE = 3;

   logic       clk_26 = 1'b0;
   logic       rst_n = 1'b0;
   logic       lock_i = 1'b0;
   logic [2:0] ack_i = 3'b000;
   logic       restart_i = 1'b0;
   logic [2:0] enable_o;
   logic [2:0] state_o;
   logic [2:0] stage_o;
   logic       fault_o;
   logic       led_o;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk_26 = ~clk_26;

   startup_sequencer #(
      .STAGES     (STAGES),
      .LOCK_FILTER(LF),
      .STAGE_DELAY(SD),
      .TIMEOUT    (TO),
      .ACK_MASK   (MASK),
      .FLASH_BITS (FB)
   ) dut (
      .clk_26   (clk_26),
      .rst_n    (rst_n),
      .lock_i   (lock_i),
      .ack_i    (ack_i),
      .restart_i(restart_i),
      .enable_o (enable_o),
      .state_o  (state_o),
      .stage_o  (stage_o),
      .fault_o  (fault_o),
      .led_o    (led_o)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Inputs as the DUT sees them at each active edge.
   logic       s_rst = 1'b0;
   logic       s_lock = 1'b0;
   logic [2:0] s_ack = 3'b000;
   logic       s_restart = 1'b0;

   always @(posedge clk_26) begin
      s_rst     <= rst_n;
      s_lock    <= lock_i;
      s_ack     <= ack_i;
      s_restart <= restart_i;
   end

   // Model: phase number plus age in cycles since the phase began; sync as 2-deep delay lines.
   int         m_state, m_stage, m_run, m_age, m_flash;
   logic [2:0] m_en;
   logic       m_fault, m_led;
   bit         lock_q[$];
   logic [2:0] ack_q[$];

   function automatic logic led_for(input int st, input int fl);
      if (st == 2 || st == 3) return 1'((fl >> (FB - 1)) & 1);
      if (st == 4) return 1'b1;
      if (st == 5) return 1'((fl >> (FB - 3)) & 1);
      return 1'b0;
   endfunction

   task automatic enter_wait_lock();
      m_state = 1;
      m_en    = 3'b000;
      m_stage = 0;
      m_run   = 0;
   endtask

   task automatic enter_delay(input int s);
      m_state = 2;
      m_stage = s;
      m_age   = 0;
   endtask

   task automatic model_step();
      bit         ls;
      logic [2:0] as;
      bit         acked;
      if (!s_rst) begin
         m_state = 0; m_stage = 0; m_run = 0; m_age = 0; m_flash = 0;
         m_en = 3'b000; m_fault = 1'b0; m_led = 1'b0;
         lock_q = '{1'b0, 1'b0};
         ack_q  = '{3'b000, 3'b000};
         return;
      end
      ls = lock_q.pop_front();
      lock_q.push_back(s_lock);
      as = ack_q.pop_front();
      ack_q.push_back(s_ack);
      m_led   = led_for(m_state, m_flash);
      m_flash = (m_flash + 1) % (1 << FB);
      m_age++;
      if (!ls && (m_state == 2 || m_state == 3 || m_state == 4)) begin
         enter_wait_lock();
      end else if (s_restart && m_state != 0) begin
         enter_wait_lock();
         m_fault = 1'b0;
      end else begin
         case (m_state)
            0: enter_wait_lock();
            1: begin
               m_run = ls ? m_run + 1 : 0;
               if (m_run == LF) enter_delay(0);
            end
            2: if (m_age == SD) begin
               m_en    = m_en | 3'(1 << m_stage);
               m_state = 3;
               m_age   = 0;
            end
            3: begin
               acked = (((int'(MASK) >> m_stage) & 1) == 0) || (((int'(as) >> m_stage) & 1) == 1);
               if (acked) begin
                  if (m_stage == STAGES - 1) m_state = 4;
                  else enter_delay(m_stage + 1);
               end else if (TO != 0 && m_age == TO) begin
                  m_state = 5;
                  m_fault = 1'b1;
                  m_en    = 3'b000;
               end
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      forever begin
         @(negedge clk_26);
         model_step();
         check("cyc_enable", 32'(enable_o), 32'(m_en));
         check("cyc_state", 32'(state_o), 32'(m_state));
         check("cyc_stage", 32'(stage_o), 32'(m_stage));
         check("cyc_fault", 32'(fault_o), 32'(m_fault));
         check("cyc_led", 32'(led_o), 32'(m_led));
         cyc++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_26);
         #1;
      end
   endtask

   function automatic logic [31:0] probe(input int sel);
      case (sel)
         SEL_EN:    return 32'(enable_o);
         SEL_FAULT: return 32'(fault_o);
         SEL_LED:   return 32'(led_o);
         default:   return 32'(state_o);
      endcase
   endfunction

   task automatic wait_for(input int sel, input logic [31:0] val, input int budget, output int n);
      n = 0;
      while (probe(sel) !== val && n < budget) begin
         step(1);
         n++;
      end
   endtask

   task automatic wait_led_change(input int budget, output int n);
      logic lv;
      lv = led_o;
      n = 0;
      while (led_o === lv && n < budget) begin
         step(1);
         n++;
      end
   endtask

   task automatic pulse_restart();
      restart_i = 1'b1;
      step(1);
      restart_i = 1'b0;
   endtask

   initial begin
      int n;
      int g;
      rst_n = 1'b0;
      lock_i = 1'b1;
      ack_i = 3'b000;
      restart_i = 1'b0;
      step(3);
      check("rst_enable", 32'(enable_o), 0);
      check("rst_state", 32'(state_o), 0);
      check("rst_led", 32'(led_o), 0);
      rst_n = 1'b1;
      check("release_state", 32'(state_o), 0);

      // Clean power-up; the lock synchroniser fills during the RESET cycle.
      wait_for(SEL_EN, 3'b001, 60, n);
      check("en0_latency", n, 2 + LF + SD);
      wait_for(SEL_EN, 3'b011, 40, n);
      check("en1_spacing", n, SD + 1);
      step(10);
      ack_i[1] = 1'b1;
      wait_for(SEL_EN, 3'b111, 40, n);
      check("ack_to_en2", n, 2 + 1 + SD);
      step(2);
      check("run_state", 32'(state_o), 4);
      check("run_led", 32'(led_o), 1);

      // Lock loss in RUN, then relock.
      lock_i = 1'b0;
      wait_for(SEL_EN, 3'b000, 10, n);
      check("lockloss_latency", n, 3);
      check("lockloss_state", 32'(state_o), 1);
      lock_i = 1'b1;
      wait_for(SEL_EN, 3'b001, 60, n);
      check("relock_en0", n, 2 + LF + SD);
      wait_for(SEL_EN, 3'b111, 60, n);
      check("relock_en2", n, 2 * (SD + 1));

      // Lock glitch during WAIT_LOCK: g high cycles, one low, then high.
      lock_i = 1'b0;
      step(5);
      g = $urandom_range(0, LF - 1);
      lock_i = 1'b1;
      step(g);
      lock_i = 1'b0;
      step(1);
      lock_i = 1'b1;
      wait_for(SEL_EN, 3'b001, 80, n);
      check("glitch_en0", g + 1 + n, 2 + LF + SD + g + 1);

      // Stage time-out on the acked stage.
      ack_i = 3'b000;
      wait_for(SEL_EN, 3'b011, 40, n);
      check("to_en1", n, SD + 1);
      wait_for(SEL_FAULT, 1, 100, n);
      check("to_latency", n, TO);
      check("to_enable", 32'(enable_o), 0);
      check("to_state", 32'(state_o), 5);
      wait_led_change(20, n);
      wait_led_change(20, n);
      check("fault_led_half", n, 8);
      wait_led_change(20, n);
      check("fault_led_half2", n, 8);
      pulse_restart();
      check("restart_fault", 32'(fault_o), 0);
      check("restart_state", 32'(state_o), 1);
      wait_for(SEL_EN, 3'b001, 60, n);
      check("restart_en0", n + 1, 1 + LF + SD);

      // Restart mid-DELAY.
      step(3);
      check("middelay_state", 32'(state_o), 2);
      pulse_restart();
      check("middelay_enable", 32'(enable_o), 0);
      check("middelay_stage", 32'(stage_o), 0);
      wait_for(SEL_EN, 3'b001, 60, n);
      check("middelay_en0", n + 1, 1 + LF + SD);

      // Reset mid-WAIT_ACK.
      wait_for(SEL_EN, 3'b011, 40, n);
      step(5);
      check("midack_state", 32'(state_o), 3);
      rst_n = 1'b0;
      step(1);
      check("midrst_enable", 32'(enable_o), 0);
      check("midrst_state", 32'(state_o), 0);
      check("midrst_fault", 32'(fault_o), 0);
      rst_n = 1'b1;
      wait_for(SEL_EN, 3'b001, 60, n);
      check("midrst_en0", n, 2 + LF + SD);

      // Ack lands on the time-out cycle: ack wins.
      wait_for(SEL_EN, 3'b011, 40, n);
      step(TO - 3);
      ack_i[1] = 1'b1;
      step(3);
      check("ack_vs_to_fault", 32'(fault_o), 0);
      check("ack_vs_to_state", 32'(state_o), 2);
      check("ack_vs_to_stage", 32'(stage_o), 2);
      wait_for(SEL_EN, 3'b111, 20, n);
      ack_i = 3'b000;

      // Lock loss on the time-out cycle.
      pulse_restart();
      wait_for(SEL_EN, 3'b011, 60, n);
      step(TO - 3);
      lock_i = 1'b0;
      step(3);
      check("lock_vs_to_state", 32'(state_o), 1);
      check("lock_vs_to_fault", 32'(fault_o), 0);

      // Restart on the time-out cycle.
      lock_i = 1'b1;
      wait_for(SEL_EN, 3'b011, 60, n);
      step(TO - 1);
      pulse_restart();
      check("restart_vs_to_state", 32'(state_o), 1);
      check("restart_vs_to_fault", 32'(fault_o), 0);

      // Lock loss, ack and restart all on one edge.
      wait_for(SEL_EN, 3'b011, 60, n);
      step(2);
      lock_i = 1'b0;
      ack_i[1] = 1'b1;
      step(2);
      pulse_restart();
      check("triple_state", 32'(state_o), 1);
      check("triple_enable", 32'(enable_o), 0);
      step(2);
      check("triple_hold", 32'(state_o), 1);

      // Random phase.
      lock_i = 1'b1;
      ack_i = 3'b000;
      for (int i = 0; i < 3000; i++) begin
         if (lock_i) begin
            if ($urandom_range(0, 199) == 0) lock_i = 1'b0;
         end else if ($urandom_range(0, 9) == 0) begin
            lock_i = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) ack_i = 3'($urandom_range(0, 7));
         restart_i = ($urandom_range(0, 299) == 0);
         rst_n = ($urandom_range(0, 999) != 0);
         step(1);
      end
      restart_i = 1'b0;
      rst_n = 1'b1;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
